// File: rtl/div_nbit_seq.sv
// Purpose: unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Latency: done is high N+1 cycles after start is accepted (1 cycle for divide-by-zero).
// Backpressure: start is accepted only in IDLE; start while busy is dropped, not queued.
module div_nbit_seq #(
    parameter int N  = 16,
    parameter int CW = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [N-1:0]   d_reg, d_nx;       // dividend shifting out, quotient shifting in
    logic [N-1:0]   v_reg, v_nx;       // divisor
    logic [N:0]     rem, rem_nx;       // partial remainder
    logic [CW-1:0]  count, count_nx;
    logic [N-1:0]   q_nx, r_nx;
    logic           busy_nx, done_nx, div0_nx;

    // The partial remainder is always below the divisor, so its top bit is
    // zero; subtracting at N+2 bits makes the top result bit the borrow.
    logic [N+1:0]   shifted;
    logic [N+1:0]   trial;
    logic           borrow;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {rem, d_reg[N-1]};
        trial   = shifted - {2'b00, v_reg};
        borrow  = trial[N+1];
    end

    // Next-state and next-register logic; every register holds by default
    always_comb begin
        state_nx = state;
        d_nx     = d_reg;
        v_nx     = v_reg;
        rem_nx   = rem;
        count_nx = count;
        q_nx     = q;
        r_nx     = r;
        busy_nx  = busy;
        done_nx  = 1'b0;
        div0_nx  = div0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy_nx = 1'b1;
                    if (B != '0) begin
                        d_nx     = A;
                        v_nx     = B;
                        rem_nx   = '0;
                        count_nx = CW'(N);
                        div0_nx  = 1'b0;
                        state_nx = CALC;
                    end else begin
                        // Divide-by-zero results are fixed, so load them now
                        q_nx     = '1;
                        r_nx     = A;
                        div0_nx  = 1'b1;
                        state_nx = FIN;
                    end
                end
            end
            CALC: begin
                rem_nx   = borrow ? shifted[N:0] : trial[N:0];
                d_nx     = {d_reg[N-2:0], ~borrow};
                count_nx = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                if (!div0) begin
                    q_nx = d_reg;
                    r_nx = rem[N-1:0];
                end
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            d_reg <= '0;
            v_reg <= '0;
            rem   <= '0;
            count <= '0;
            q     <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_nx;
            d_reg <= d_nx;
            v_reg <= v_nx;
            rem   <= rem_nx;
            count <= count_nx;
            q     <= q_nx;
            r     <= r_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            div0  <= div0_nx;
        end
    end

endmodule

// File: tb/tb_div_nbit_seq.sv
// Self-checking bench for div_nbit_seq against a plain-arithmetic reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Every wait on done is bounded by a cycle budget.
module tb_div_nbit_seq;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A, B;
    logic [N-1:0] q, r;
    logic         busy, done, div0;

    int errors = 0;
    int checks = 0;

    div_nbit_seq #(.N(N), .CW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .q(q), .r(r), .busy(busy), .done(done), .div0(div0)
    );

    always #5 clk = ~clk;

    // Reference model: unsigned division with the divide-by-zero convention
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] eq, output logic [N-1:0] er,
                                    output logic ed0);
        if (b == 0) begin
            eq = '1; er = a; ed0 = 1'b1;
        end else begin
            eq = a / b; er = a % b; ed0 = 1'b0;
        end
    endfunction

    // Issue one start pulse and wait for done; lat counts edges after the start edge
    task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          output int lat, output int busy_cnt);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        checks++; if (q !== 16'd0)  begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
        checks++; if (r !== 16'd0)  begin errors++; $display("FAIL reset_r: got %0d expected 0", r); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL reset_div0: got %b expected 0", div0); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [N-1:0] ta [8];
        logic [N-1:0] tb [8];
        logic [N-1:0] eq, er, q_hold;
        logic ed0;
        int lat, bc;
        ta[0] = 16'd100;   tb[0] = 16'd7;
        ta[1] = 16'hFFFF;  tb[1] = 16'd1;
        ta[2] = 16'd5;     tb[2] = 16'd10;
        ta[3] = 16'hFFFF;  tb[3] = 16'hFFFF;
        ta[4] = 16'd0;     tb[4] = 16'd3;
        ta[5] = 16'h8000;  tb[5] = 16'h8000;
        ta[6] = N'($urandom); tb[6] = N'($urandom_range(1, 255));
        ta[7] = N'($urandom); tb[7] = N'($urandom_range(1, 65535));
        for (int i = 0; i < 8; i++) begin
            ref_div(ta[i], tb[i], eq, er, ed0);
            do_div(ta[i], tb[i], lat, bc);
            checks++; if (lat !== N + 1) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, N + 1); end
            checks++; if (bc !== N + 1) begin errors++; $display("FAIL basic_busy_cycles[%0d]: got %0d expected %0d", i, bc, N + 1); end
            checks++; if (q !== eq) begin errors++; $display("FAIL basic_q[%0d]: got %0d expected %0d", i, q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL basic_r[%0d]: got %0d expected %0d", i, r, er); end
            checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL basic_div0[%0d]: got %b expected 0", i, div0); end
            q_hold = q;
            @(negedge clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse[%0d]: got %b expected 0", i, done); end
            checks++; if (q !== q_hold) begin errors++; $display("FAIL basic_q_hold[%0d]: got %0d expected %0d", i, q, q_hold); end
        end
    endtask

    task automatic test_div0();
        int lat, bc;
        do_div(16'd1234, 16'd0, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency: got %0d expected 1", lat); end
        checks++; if (bc !== 1) begin errors++; $display("FAIL div0_busy_cycles: got %0d expected 1", bc); end
        checks++; if (q !== 16'hFFFF) begin errors++; $display("FAIL div0_q: got %0h expected ffff", q); end
        checks++; if (r !== 16'd1234) begin errors++; $display("FAIL div0_r: got %0d expected 1234", r); end
        checks++; if (div0 !== 1'b1) begin errors++; $display("FAIL div0_flag: got %b expected 1", div0); end
        do_div(16'd9, 16'd3, lat, bc);
        checks++; if (lat !== N + 1) begin errors++; $display("FAIL div0_after_latency: got %0d expected %0d", lat, N + 1); end
        checks++; if (div0 !== 1'b0) begin errors++; $display("FAIL div0_after_flag: got %b expected 0", div0); end
        checks++; if (q !== 16'd3) begin errors++; $display("FAIL div0_after_q: got %0d expected 3", q); end
        checks++; if (r !== 16'd0) begin errors++; $display("FAIL div0_after_r: got %0d expected 0", r); end
    endtask

    task automatic test_ignore_start();
        int lat;
        A = 16'd50; B = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 4) begin
                A = 16'd7; B = 16'd2; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++; if (lat !== N + 1) begin errors++; $display("FAIL ignore_latency: got %0d expected %0d", lat, N + 1); end
        checks++; if (q !== 16'd10) begin errors++; $display("FAIL ignore_q: got %0d expected 10", q); end
        checks++; if (r !== 16'd0) begin errors++; $display("FAIL ignore_r: got %0d expected 0", r); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_not_queued: got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_abort();
        int lat, bc, seen;
        A = 16'd1000; B = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (q !== 16'd0) begin errors++; $display("FAIL abort_q: got %0d expected 0", q); end
        checks++; if (r !== 16'd0) begin errors++; $display("FAIL abort_r: got %0d expected 0", r); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (done) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
        do_div(16'd1000, 16'd3, lat, bc);
        checks++; if (q !== 16'd333) begin errors++; $display("FAIL abort_retry_q: got %0d expected 333", q); end
        checks++; if (r !== 16'd1) begin errors++; $display("FAIL abort_retry_r: got %0d expected 1", r); end
        checks++; if (lat !== N + 1) begin errors++; $display("FAIL abort_retry_latency: got %0d expected %0d", lat, N + 1); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] a, b, eq, er;
        logic ed0;
        logic [31:0] recon;
        int lat, sel;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 7);
            a = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 40)) : N'($urandom);
            if (sel == 0)      b = '0;
            else if (sel == 1) b = N'($urandom_range(1, 15));
            else               b = N'($urandom_range(1, 65535));
            ref_div(a, b, eq, er, ed0);
            A = a; B = b;
            @(negedge clk);
            lat = 0;
            while (!done && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== (ed0 ? 1 : N + 1)) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, ed0 ? 1 : N + 1); end
            checks++; if (q !== eq) begin errors++; $display("FAIL b2b_q[%0d] a=%0d b=%0d: got %0d expected %0d", i, a, b, q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL b2b_r[%0d] a=%0d b=%0d: got %0d expected %0d", i, a, b, r, er); end
            checks++; if (div0 !== ed0) begin errors++; $display("FAIL b2b_div0[%0d]: got %b expected %b", i, div0, ed0); end
            if (b != 0) begin
                recon = {16'd0, q} * {16'd0, b} + {16'd0, r};
                checks++; if (recon !== {16'd0, a}) begin errors++; $display("FAIL b2b_invariant[%0d]: got q*b+r=%0d expected %0d", i, recon, a); end
                checks++; if (!(r < b)) begin errors++; $display("FAIL b2b_rem_bound[%0d]: got r=%0d expected below %0d", i, r, b); end
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        test_reset();
        test_basic();
        test_div0();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
